// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the instruction-decode stage: alu operation codes,
// MIPS opcode/funct constants and the decoded control bundle.
package id_stage_pkg;

   typedef enum logic [4:0] {
      ALUOP_SLL = 5'd0,
      ALUOP_SRL = 5'd1,
      ALUOP_SRA = 5'd2,
      ALUOP_ADD = 5'd3,
      ALUOP_SUB = 5'd4,
      ALUOP_AND = 5'd5,
      ALUOP_OR  = 5'd6,
      ALUOP_XOR = 5'd7,
      ALUOP_NOR = 5'd8,
      ALUOP_SLT = 5'd9,
      ALUOP_LUI = 5'd10,
      ALUOP_BEQ = 5'd11,
      ALUOP_BNE = 5'd12,
      ALUOP_MUL = 5'd13,
      ALUOP_DIV = 5'd14
   } aluop_e;

   localparam logic [5:0] OPC_RTYPE    = 6'h00;
   localparam logic [5:0] OPC_BEQ      = 6'h04;
   localparam logic [5:0] OPC_BNE      = 6'h05;
   localparam logic [5:0] OPC_ADDI     = 6'h08;
   localparam logic [5:0] OPC_ADDIU    = 6'h09;
   localparam logic [5:0] OPC_SLTI     = 6'h0A;
   localparam logic [5:0] OPC_ANDI     = 6'h0C;
   localparam logic [5:0] OPC_ORI      = 6'h0D;
   localparam logic [5:0] OPC_XORI     = 6'h0E;
   localparam logic [5:0] OPC_LUI      = 6'h0F;
   localparam logic [5:0] OPC_SPECIAL2 = 6'h1C;
   localparam logic [5:0] OPC_LW       = 6'h23;
   localparam logic [5:0] OPC_SW       = 6'h2B;

   localparam logic [5:0] FUNCT_SLL  = 6'h00;
   localparam logic [5:0] FUNCT_SRL  = 6'h02;
   localparam logic [5:0] FUNCT_SRA  = 6'h03;
   localparam logic [5:0] FUNCT_DIV  = 6'h1A;
   localparam logic [5:0] FUNCT_ADD  = 6'h20;
   localparam logic [5:0] FUNCT_ADDU = 6'h21;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] FUNCT_SUBU = 6'h23;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_XOR  = 6'h26;
   localparam logic [5:0] FUNCT_NOR  = 6'h27;
   localparam logic [5:0] FUNCT_SLT  = 6'h2A;
   localparam logic [5:0] FUNCT_MUL  = 6'h02;

   typedef struct packed {
      aluop_e     aluop;
      logic [4:0] shamt;
      logic [4:0] s_idx;
      logic [4:0] t_idx;
      logic [4:0] dst_idx;
      logic       use_imm;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       illegal;
   } dec_ctrl_t;

endpackage

// File: rtl/id_stage_instr_decode.sv
// Purely combinational 32-bit MIPS instruction decoder producing the alu control bundle.
// ACE_MULDIV_EN enables the MUL (special2) and DIV (R-type) encodings; otherwise they decode illegal.
module instr_decode
   import id_stage_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic [31:0]  i_instr,
   output dec_ctrl_t    o_ctrl,
   output logic [N-1:0] o_imm
);

`ifdef ACE_MULDIV_EN
   localparam bit MULDIV_EN = 1'b1;
`else
   localparam bit MULDIV_EN = 1'b0;
`endif

   logic [5:0]   w_opc;
   logic [5:0]   w_funct;
   logic [4:0]   w_rs;
   logic [4:0]   w_rt;
   logic [4:0]   w_rd;
   logic [N-1:0] w_sext;
   logic [N-1:0] w_zext;

   assign w_opc   = i_instr[31:26];
   assign w_rs    = i_instr[25:21];
   assign w_rt    = i_instr[20:16];
   assign w_rd    = i_instr[15:11];
   assign w_funct = i_instr[5:0];
   assign w_sext  = {{(N-16){i_instr[15]}}, i_instr[15:0]};
   assign w_zext  = {{(N-16){1'b0}}, i_instr[15:0]};

   always_comb begin
      o_ctrl         = '0;
      o_ctrl.aluop   = ALUOP_SLL;
      o_ctrl.s_idx   = w_rs;
      o_ctrl.t_idx   = w_rt;
      o_ctrl.dst_idx = (w_opc == OPC_RTYPE || w_opc == OPC_SPECIAL2) ? w_rd : w_rt;
      o_imm          = w_sext;

      case (w_opc)
         OPC_RTYPE: begin
            o_ctrl.reg_write = 1'b1;
            case (w_funct)
               FUNCT_SLL: begin
                  o_ctrl.aluop = ALUOP_SLL;
                  o_ctrl.shamt = i_instr[10:6];
                  o_ctrl.s_idx = w_rt;
               end
               FUNCT_SRL: begin
                  o_ctrl.aluop = ALUOP_SRL;
                  o_ctrl.shamt = i_instr[10:6];
                  o_ctrl.s_idx = w_rt;
               end
               FUNCT_SRA: begin
                  o_ctrl.aluop = ALUOP_SRA;
                  o_ctrl.shamt = i_instr[10:6];
                  o_ctrl.s_idx = w_rt;
               end
               FUNCT_ADD, FUNCT_ADDU: o_ctrl.aluop = ALUOP_ADD;
               FUNCT_SUB, FUNCT_SUBU: o_ctrl.aluop = ALUOP_SUB;
               FUNCT_AND:             o_ctrl.aluop = ALUOP_AND;
               FUNCT_OR:              o_ctrl.aluop = ALUOP_OR;
               FUNCT_XOR:             o_ctrl.aluop = ALUOP_XOR;
               FUNCT_NOR:             o_ctrl.aluop = ALUOP_NOR;
               FUNCT_SLT:             o_ctrl.aluop = ALUOP_SLT;
               FUNCT_DIV: begin
                  if (MULDIV_EN) o_ctrl.aluop   = ALUOP_DIV;
                  else           o_ctrl.illegal = 1'b1;
               end
               default:               o_ctrl.illegal = 1'b1;
            endcase
         end
         OPC_SPECIAL2: begin
            o_ctrl.reg_write = 1'b1;
            if (MULDIV_EN && w_funct == FUNCT_MUL) o_ctrl.aluop   = ALUOP_MUL;
            else                                   o_ctrl.illegal = 1'b1;
         end
         OPC_ADDI, OPC_ADDIU: begin
            o_ctrl.aluop     = ALUOP_ADD;
            o_ctrl.use_imm   = 1'b1;
            o_ctrl.reg_write = 1'b1;
         end
         OPC_SLTI: begin
            o_ctrl.aluop     = ALUOP_SLT;
            o_ctrl.use_imm   = 1'b1;
            o_ctrl.reg_write = 1'b1;
         end
         OPC_ANDI: begin
            o_ctrl.aluop     = ALUOP_AND;
            o_ctrl.use_imm   = 1'b1;
            o_ctrl.reg_write = 1'b1;
            o_imm            = w_zext;
         end
         OPC_ORI: begin
            o_ctrl.aluop     = ALUOP_OR;
            o_ctrl.use_imm   = 1'b1;
            o_ctrl.reg_write = 1'b1;
            o_imm            = w_zext;
         end
         OPC_XORI: begin
            o_ctrl.aluop     = ALUOP_XOR;
            o_ctrl.use_imm   = 1'b1;
            o_ctrl.reg_write = 1'b1;
            o_imm            = w_zext;
         end
         // alu performs the <<16 itself; the raw immediate is passed through
         OPC_LUI: begin
            o_ctrl.aluop     = ALUOP_LUI;
            o_ctrl.use_imm   = 1'b1;
            o_ctrl.reg_write = 1'b1;
            o_imm            = w_zext;
         end
         OPC_LW: begin
            o_ctrl.aluop     = ALUOP_ADD;
            o_ctrl.use_imm   = 1'b1;
            o_ctrl.reg_write = 1'b1;
            o_ctrl.mem_read  = 1'b1;
         end
         OPC_SW: begin
            o_ctrl.aluop     = ALUOP_ADD;
            o_ctrl.use_imm   = 1'b1;
            o_ctrl.mem_write = 1'b1;
         end
         OPC_BEQ: begin
            o_ctrl.aluop  = ALUOP_BEQ;
            o_ctrl.branch = 1'b1;
         end
         OPC_BNE: begin
            o_ctrl.aluop  = ALUOP_BNE;
            o_ctrl.branch = 1'b1;
         end
         default: o_ctrl.illegal = 1'b1;
      endcase

      if (o_ctrl.illegal) begin
         o_ctrl.aluop     = ALUOP_SLL;
         o_ctrl.shamt     = '0;
         o_ctrl.use_imm   = 1'b0;
         o_ctrl.reg_write = 1'b0;
         o_ctrl.mem_read  = 1'b0;
         o_ctrl.mem_write = 1'b0;
         o_ctrl.branch    = 1'b0;
      end
      if (o_ctrl.dst_idx == 5'd0) o_ctrl.reg_write = 1'b0;
   end

endmodule

// File: rtl/id_stage.sv
// Registered valid/ready decode stage with flush; decoding itself lives in instr_decode.
// ACE_MULDIV_EN (consumed by instr_decode) adds the MUL/DIV encodings.
module id_stage
   import id_stage_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_instr,
   input  logic [N-1:0] in_pc,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [4:0]   out_aluop,
   output logic [4:0]   out_shamt,
   output logic [4:0]   out_s_idx,
   output logic [4:0]   out_t_idx,
   output logic [4:0]   out_dst_idx,
   output logic [N-1:0] out_imm,
   output logic         out_use_imm,
   output logic         out_reg_write,
   output logic         out_mem_read,
   output logic         out_mem_write,
   output logic         out_branch,
   output logic         out_illegal,
   output logic [N-1:0] out_pc
);

   dec_ctrl_t    w_ctrl;
   logic [N-1:0] w_imm;
   logic         w_accept;

   dec_ctrl_t    r_ctrl;
   logic [N-1:0] r_imm;
   logic [N-1:0] r_pc;
   logic         r_valid;

   instr_decode #(.N(N)) u_decode (
      .i_instr (in_instr),
      .o_ctrl  (w_ctrl),
      .o_imm   (w_imm)
   );

   assign in_ready = rst_n & ~flush & (~r_valid | out_ready);
   assign w_accept = in_valid & in_ready;

   // flush wins over everything; a held bundle only leaves when consumed or replaced
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
         r_imm   <= '0;
         r_pc    <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_ctrl  <= w_ctrl;
         r_imm   <= w_imm;
         r_pc    <= in_pc;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid     = r_valid;
   assign out_aluop     = r_ctrl.aluop;
   assign out_shamt     = r_ctrl.shamt;
   assign out_s_idx     = r_ctrl.s_idx;
   assign out_t_idx     = r_ctrl.t_idx;
   assign out_dst_idx   = r_ctrl.dst_idx;
   assign out_imm       = r_imm;
   assign out_use_imm   = r_ctrl.use_imm;
   assign out_reg_write = r_ctrl.reg_write;
   assign out_mem_read  = r_ctrl.mem_read;
   assign out_mem_write = r_ctrl.mem_write;
   assign out_branch    = r_ctrl.branch;
   assign out_illegal   = r_ctrl.illegal;
   assign out_pc        = r_pc;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: queue-based handshake model with a mnemonic-level decoder,
// checked every cycle, plus literal expectations for the reference instructions.
module tb_id_stage;
   import id_stage_pkg::*;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0]  in_instr;
   logic [N-1:0] in_pc, out_imm, out_pc;
   logic [4:0]   out_aluop, out_shamt, out_s_idx, out_t_idx, out_dst_idx;
   logic         out_use_imm, out_reg_write, out_mem_read, out_mem_write, out_branch, out_illegal;

   id_stage #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_aluop(out_aluop), .out_shamt(out_shamt), .out_s_idx(out_s_idx),
      .out_t_idx(out_t_idx), .out_dst_idx(out_dst_idx), .out_imm(out_imm),
      .out_use_imm(out_use_imm), .out_reg_write(out_reg_write),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_branch(out_branch), .out_illegal(out_illegal), .out_pc(out_pc)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      else             n_pass++;
   endtask

   typedef struct packed {
      logic        legal;
      logic [4:0]  aluop;
      logic [4:0]  shamt;
      logic [4:0]  s;
      logic [4:0]  t;
      logic [4:0]  dst;
      logic        use_imm;
      logic [31:0] imm;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        br;
   } exp_t;

   function automatic exp_t model(input logic [31:0] ins);
      exp_t       e;
      logic [5:0] op, fn;
      bit         muldiv;
      op     = ins[31:26];
      fn     = ins[5:0];
      muldiv = 1'b0;
`ifdef ACE_MULDIV_EN
      muldiv = 1'b1;
`endif
      e       = '0;
      e.legal = 1'b1;
      e.s     = ins[25:21];
      e.t     = ins[20:16];
      if (op == 6'h00 || op == 6'h1C) begin
         e.dst = ins[15:11];
         e.rw  = 1'b1;
         if (op == 6'h1C) begin
            if (muldiv && fn == 6'h02) e.aluop = ALUOP_MUL;
            else                       e.legal = 1'b0;
         end else if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) begin
            e.aluop = (fn == 6'h00) ? ALUOP_SLL : (fn == 6'h02) ? ALUOP_SRL : ALUOP_SRA;
            e.shamt = ins[10:6];
            e.s     = ins[20:16];
         end else begin
            case (fn)
               6'h20, 6'h21: e.aluop = ALUOP_ADD;
               6'h22, 6'h23: e.aluop = ALUOP_SUB;
               6'h24:        e.aluop = ALUOP_AND;
               6'h25:        e.aluop = ALUOP_OR;
               6'h26:        e.aluop = ALUOP_XOR;
               6'h27:        e.aluop = ALUOP_NOR;
               6'h2A:        e.aluop = ALUOP_SLT;
               6'h1A:        if (muldiv) e.aluop = ALUOP_DIV; else e.legal = 1'b0;
               default:      e.legal = 1'b0;
            endcase
         end
      end else begin
         e.dst     = ins[20:16];
         e.use_imm = 1'b1;
         e.rw      = 1'b1;
         e.imm     = {{16{ins[15]}}, ins[15:0]};
         case (op)
            6'h08, 6'h09: e.aluop = ALUOP_ADD;
            6'h0A:        e.aluop = ALUOP_SLT;
            6'h0C: begin e.aluop = ALUOP_AND; e.imm = {16'h0, ins[15:0]}; end
            6'h0D: begin e.aluop = ALUOP_OR;  e.imm = {16'h0, ins[15:0]}; end
            6'h0E: begin e.aluop = ALUOP_XOR; e.imm = {16'h0, ins[15:0]}; end
            6'h0F: begin e.aluop = ALUOP_LUI; e.imm = {16'h0, ins[15:0]}; end
            6'h23: begin e.aluop = ALUOP_ADD; e.mr = 1'b1; end
            6'h2B: begin e.aluop = ALUOP_ADD; e.mw = 1'b1; e.rw = 1'b0; end
            6'h04: begin e.aluop = ALUOP_BEQ; e.br = 1'b1; e.rw = 1'b0; e.use_imm = 1'b0; end
            6'h05: begin e.aluop = ALUOP_BNE; e.br = 1'b1; e.rw = 1'b0; e.use_imm = 1'b0; end
            default: e.legal = 1'b0;
         endcase
      end
      if (!e.legal) begin
         e.aluop = ALUOP_SLL;
         e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.br = 1'b0;
      end
      if (e.dst == 5'd0) e.rw = 1'b0;
      return e;
   endfunction

   // at most one bundle can be in the stage: the queue holds {pc, instr} of it
   logic [63:0] q[$];

   always @(posedge clk) begin
      if (!rst_n || flush) begin
         q.delete();
      end else begin
         if (q.size() != 0 && out_ready) void'(q.pop_front());
         if (in_valid && q.size() == 0) q.push_back({in_pc, in_instr});
      end
   end

   exp_t ce;
   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready", in_ready, rst_n && !flush && (q.size() == 0 || out_ready));
         check("out_valid", out_valid, q.size() != 0);
         if (q.size() != 0) begin
            ce = model(q[0][31:0]);
            check("out_pc", out_pc, q[0][63:32]);
            check("illegal", out_illegal, !ce.legal);
            check("aluop", out_aluop, ce.aluop);
            check("reg_write", out_reg_write, ce.rw);
            check("mem_read", out_mem_read, ce.mr);
            check("mem_write", out_mem_write, ce.mw);
            check("branch", out_branch, ce.br);
            if (ce.legal) begin
               check("shamt", out_shamt, ce.shamt);
               check("s_idx", out_s_idx, ce.s);
               check("t_idx", out_t_idx, ce.t);
               check("dst_idx", out_dst_idx, ce.dst);
               check("use_imm", out_use_imm, ce.use_imm);
               if (ce.use_imm || ce.br) check("imm", out_imm, ce.imm);
            end
         end
      end
   end

   task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl);
      in_valid  = v;
      in_instr  = ins;
      in_pc     = pc;
      out_ready = rdy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] I_ADD  = 32'h00221820;
   localparam logic [31:0] I_LUI  = 32'h3C051234;
   localparam logic [31:0] I_SLL  = 32'h000220C0;
   localparam logic [31:0] I_BEQ  = 32'h10220004;
   localparam logic [31:0] I_MUL  = 32'h70221802;
   localparam logic [31:0] I_LW   = 32'h8C43FFFC;
   localparam logic [31:0] I_SW   = 32'hAC43FFFC;
   localparam logic [31:0] I_ORI  = 32'h3443FFFC;
   localparam logic [31:0] I_SRA  = 32'h000218C3;
   localparam logic [31:0] I_SUB  = 32'h00432022;
   localparam logic [31:0] I_OR   = 32'h00852825;
   localparam logic [31:0] I_AND  = 32'h00C73024;
   localparam logic [31:0] I_BAD  = 32'hFC000000;

   logic [31:0] tbl [8];

   initial begin
      tbl = '{I_ADD, I_LUI, I_SLL, I_BEQ, I_LW, I_SW, I_ORI, I_SRA};
      rst_n = 1'b0;
      cyc(1'b1, I_ADD, 32'h100, 1'b1, 1'b0);
      chk_en = 1'b1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_aluop", out_aluop, 0);
      check("rst_pc", out_pc, 0);
      check("rst_imm", out_imm, 0);
      check("rst_reg_write", out_reg_write, 0);
      check("rst_dst", out_dst_idx, 0);
      rst_n = 1'b1;

      cyc(1'b1, I_ADD, 32'h100, 1'b1, 1'b0);
      check("add_valid", out_valid, 1);
      check("add_aluop", out_aluop, ALUOP_ADD);
      check("add_s", out_s_idx, 1);
      check("add_t", out_t_idx, 2);
      check("add_dst", out_dst_idx, 3);
      check("add_rw", out_reg_write, 1);

      cyc(1'b1, I_LUI, 32'h104, 1'b1, 1'b0);
      check("lui_aluop", out_aluop, ALUOP_LUI);
      check("lui_use_imm", out_use_imm, 1);
      check("lui_imm", out_imm, 32'h00001234);
      check("lui_dst", out_dst_idx, 5);

      cyc(1'b1, I_SLL, 32'h108, 1'b1, 1'b0);
      check("sll_aluop", out_aluop, ALUOP_SLL);
      check("sll_s", out_s_idx, 2);
      check("sll_shamt", out_shamt, 3);
      check("sll_dst", out_dst_idx, 4);

      cyc(1'b1, I_BEQ, 32'h10C, 1'b1, 1'b0);
      check("beq_aluop", out_aluop, ALUOP_BEQ);
      check("beq_branch", out_branch, 1);
      check("beq_imm", out_imm, 4);
      check("beq_rw", out_reg_write, 0);

      cyc(1'b1, I_MUL, 32'h110, 1'b1, 1'b0);
`ifdef ACE_MULDIV_EN
      check("mul_aluop", out_aluop, ALUOP_MUL);
      check("mul_dst", out_dst_idx, 3);
      check("mul_rw", out_reg_write, 1);
`else
      check("mul_illegal", out_illegal, 1);
      check("mul_rw", out_reg_write, 0);
      check("mul_valid", out_valid, 1);
`endif

      cyc(1'b1, 32'h0, 32'h114, 1'b1, 1'b0);
      check("nop_illegal", out_illegal, 0);
      check("nop_rw", out_reg_write, 0);

      cyc(1'b1, I_BAD, 32'h118, 1'b1, 1'b0);
      check("bad_illegal", out_illegal, 1);
      check("bad_aluop", out_aluop, ALUOP_SLL);

      cyc(1'b1, I_LW, 32'h11C, 1'b1, 1'b0);
      check("lw_imm", out_imm, 32'hFFFFFFFC);
      check("lw_mem_read", out_mem_read, 1);
      cyc(1'b1, I_SW, 32'h120, 1'b1, 1'b0);
      check("sw_mem_write", out_mem_write, 1);
      check("sw_rw", out_reg_write, 0);
      cyc(1'b1, I_ORI, 32'h124, 1'b1, 1'b0);
      check("ori_imm", out_imm, 32'h0000FFFC);

      // backpressure: bundle held for three cycles, then released
      cyc(1'b1, I_SUB, 32'h200, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, I_OR, 32'h204, 1'b0, 1'b0);
         check("stall_in_ready", in_ready, 0);
         check("stall_pc", out_pc, 32'h200);
         check("stall_aluop", out_aluop, ALUOP_SUB);
      end
      cyc(1'b1, I_OR, 32'h204, 1'b1, 1'b0);
      check("release_pc", out_pc, 32'h204);

      // flush with a held bundle and an incoming instruction
      cyc(1'b1, I_AND, 32'h208, 1'b0, 1'b1);
      check("flush_valid", out_valid, 0);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("flush_dropped", out_valid, 0);
      cyc(1'b1, I_ADD, 32'h300, 1'b1, 1'b0);
      cyc(1'b1, I_LUI, 32'h304, 1'b1, 1'b1);
      check("flush_ready_valid", out_valid, 0);

      for (int i = 0; i < 16; i++)
         cyc(i % 3 != 2, tbl[i % 8], 32'h400 + 32'(4 * i), (i % 4) != 1, i == 11);
      for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
